// File: rtl/pipeline_hazard_controller_if.sv
// Handshake bundle between the RV32I pipeline datapath and its hazard controller.
// The controller takes the slave view; the datapath (or a testbench) takes the master view.
interface pipeline_hazard_controller_if #(
    parameter int unsigned XLEN_CNT = 32
) ();
    logic [4:0]          id_rs1_i;
    logic [4:0]          id_rs2_i;
    logic [4:0]          id_rd_i;
    logic                id_uses_rs1_i;
    logic                id_uses_rs2_i;
    logic                id_reg_write_i;
    logic                branch_taken_i;
    logic                pc_write_o;
    logic                if_id_write_o;
    logic                id_ex_bubble_o;
    logic                flush_o;
    logic [1:0]          state_o;
    logic [XLEN_CNT-1:0] stall_cycles_o;
    logic [XLEN_CNT-1:0] flush_count_o;

    modport master (
        output id_rs1_i, id_rs2_i, id_rd_i, id_uses_rs1_i, id_uses_rs2_i, id_reg_write_i,
        output branch_taken_i,
        input  pc_write_o, if_id_write_o, id_ex_bubble_o, flush_o, state_o,
        input  stall_cycles_o, flush_count_o
    );

    modport slave (
        input  id_rs1_i, id_rs2_i, id_rd_i, id_uses_rs1_i, id_uses_rs2_i, id_reg_write_i,
        input  branch_taken_i,
        output pc_write_o, if_id_write_o, id_ex_bubble_o, flush_o, state_o,
        output stall_cycles_o, flush_count_o
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// RAW-stall / taken-redirect sequencer for a 5-stage RV32I pipeline with a 3-slot rd scoreboard.
// Define HAZARD_PERF_CNT_EN to build the saturating stall and flush counters.
module pipeline_hazard_controller #(
    parameter bit          RF_WRITE_THROUGH = 1'b0,
    parameter int unsigned XLEN_CNT         = 32
) (
    input logic                         clk,
    input logic                         reset,
    pipeline_hazard_controller_if.slave bus
);

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StStall = 2'd1,
        StFlush = 2'd2
    } state_e;

    state_e     r_state;
    logic       r_id_valid;
    logic       r_ex_v, r_mem_v, r_wb_v;
    logic [4:0] r_ex_rd, r_mem_rd, r_wb_rd;

    state_e     w_state_nxt;
    logic       w_id_valid_nxt;
    logic       w_ex_v_nxt, w_mem_v_nxt, w_wb_v_nxt;
    logic [4:0] w_ex_rd_nxt, w_mem_rd_nxt, w_wb_rd_nxt;
    logic       w_pc_write, w_if_id_write, w_bubble, w_flush;
    logic       w_wb_counted, w_r1, w_r2, w_hz;

    // With write-through the WB value is already visible to the ID read port.
    assign w_wb_counted = r_wb_v && !RF_WRITE_THROUGH;

    assign w_r1 = bus.id_uses_rs1_i && (bus.id_rs1_i != 5'd0) &&
                  ((r_ex_v && (r_ex_rd == bus.id_rs1_i)) ||
                   (r_mem_v && (r_mem_rd == bus.id_rs1_i)) ||
                   (w_wb_counted && (r_wb_rd == bus.id_rs1_i)));
    assign w_r2 = bus.id_uses_rs2_i && (bus.id_rs2_i != 5'd0) &&
                  ((r_ex_v && (r_ex_rd == bus.id_rs2_i)) ||
                   (r_mem_v && (r_mem_rd == bus.id_rs2_i)) ||
                   (w_wb_counted && (r_wb_rd == bus.id_rs2_i)));
    assign w_hz = r_id_valid && (w_r1 || w_r2);

    always_comb begin
        w_state_nxt    = StRun;
        w_pc_write     = 1'b1;
        w_if_id_write  = 1'b1;
        w_bubble       = 1'b0;
        w_flush        = 1'b0;
        w_id_valid_nxt = 1'b1;
        w_ex_v_nxt     = r_id_valid && bus.id_reg_write_i && (bus.id_rd_i != 5'd0);
        w_ex_rd_nxt    = bus.id_rd_i;
        w_mem_v_nxt    = r_ex_v;
        w_mem_rd_nxt   = r_ex_rd;
        w_wb_v_nxt     = r_mem_v;
        w_wb_rd_nxt    = r_mem_rd;
        if (bus.branch_taken_i) begin
            // Only the resolving branch/jump (old MEM) survives into WB.
            w_state_nxt    = StFlush;
            w_flush        = 1'b1;
            w_bubble       = 1'b1;
            w_id_valid_nxt = 1'b0;
            w_ex_v_nxt     = 1'b0;
            w_mem_v_nxt    = 1'b0;
        end else if (w_hz) begin
            w_state_nxt    = StStall;
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_bubble       = 1'b1;
            w_id_valid_nxt = r_id_valid;
            w_ex_v_nxt     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= StRun;
            r_id_valid <= 1'b0;
            r_ex_v     <= 1'b0;
            r_mem_v    <= 1'b0;
            r_wb_v     <= 1'b0;
            r_ex_rd    <= 5'd0;
            r_mem_rd   <= 5'd0;
            r_wb_rd    <= 5'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_id_valid <= w_id_valid_nxt;
            r_ex_v     <= w_ex_v_nxt;
            r_mem_v    <= w_mem_v_nxt;
            r_wb_v     <= w_wb_v_nxt;
            r_ex_rd    <= w_ex_rd_nxt;
            r_mem_rd   <= w_mem_rd_nxt;
            r_wb_rd    <= w_wb_rd_nxt;
        end
    end

    // Outputs are forced to their idle values while reset is held, whatever the inputs do.
    assign bus.pc_write_o     = w_pc_write | ~reset;
    assign bus.if_id_write_o  = w_if_id_write | ~reset;
    assign bus.id_ex_bubble_o = w_bubble & reset;
    assign bus.flush_o        = w_flush & reset;
    assign bus.state_o        = r_state;

`ifdef HAZARD_PERF_CNT_EN
    logic [XLEN_CNT-1:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_pc_write && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + XLEN_CNT'(1);
            if (w_flush && !(&r_flush_cnt))     r_flush_cnt <= r_flush_cnt + XLEN_CNT'(1);
        end
    end

    assign bus.stall_cycles_o = r_stall_cnt;
    assign bus.flush_count_o  = r_flush_cnt;
`else
    assign bus.stall_cycles_o = {XLEN_CNT{1'b0}};
    assign bus.flush_count_o  = {XLEN_CNT{1'b0}};
`endif

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Sequencer for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB). It tracks in-flight destination registers in a 3-slot scoreboard that mirrors the ID/EX, EX/MEM and MEM/WB registers. It stalls PC and IF/ID on read-after-write hazards and inserts bubbles into ID/EX. It flushes wrong-path instructions when a branch or jump resolves taken in MEM.

Parameters:
RF_WRITE_THROUGH, 0, 1 = register file returns the same-cycle WB write on read, so the WB slot is excluded from hazard checks.
XLEN_CNT, 32, width of the performance counters (optional feature).

Ports:
clk  input  1  pipeline clock, rising edge.
reset  input  1  asynchronous, active-low reset.
id_rs1_i  input  5  rs1 field of the instruction in ID.
id_rs2_i  input  5  rs2 field of the instruction in ID.
id_rd_i  input  5  rd field of the instruction in ID.
id_uses_rs1_i  input  1  ID instruction reads rs1.
id_uses_rs2_i  input  1  ID instruction reads rs2.
id_reg_write_i  input  1  ID instruction writes rd (control-unit Reg_Write).
branch_taken_i  input  1  Branch_Flag from MEM stage; PC is redirected this cycle.
pc_write_o  output  1  PC register enable.
if_id_write_o  output  1  IF/ID register enable.
id_ex_bubble_o  output  1  force all ID/EX control bits to 0.
flush_o  output  1  clear IF/ID instruction to NOP and clear ID/EX and EX/MEM control bits.
state_o  output  2  0 = RUN, 1 = STALL, 2 = FLUSH.
stall_cycles_o  output  XLEN_CNT  count of stall cycles (optional feature).
flush_count_o  output  XLEN_CNT  count of taken redirects (optional feature).

Behaviour:
- Internal state:
  - id_valid bit for the IF/ID contents.
  - Scoreboard slots EX, MEM and WB, each {v, rd[4:0]}.
  - 2-bit FSM.
- Reset (reset = 0, asynchronous):
  - id_valid = 0, all slots v = 0, FSM = RUN.
  - Outputs: pc_write_o = 1, if_id_write_o = 1, id_ex_bubble_o = 0, flush_o = 0, state_o = 0, counters = 0.
  - Reset asserted mid-stall or mid-flush aborts immediately to RUN.
- Hazard (combinational), hz = id_valid & (r1 | r2):
  - r1 = id_uses_rs1_i & rs1 != 0 & rs1 matches any counted valid slot.
  - r2 is the same test for rs2.
  - Counted slots: EX and MEM always; WB only when RF_WRITE_THROUGH = 0.
- Priority: branch_taken_i > hz > normal.
- Taken (branch_taken_i = 1), combinational this cycle:
  - flush_o = 1, pc_write_o = 1, if_id_write_o = 1, id_ex_bubble_o = 1.
  - At the edge: id_valid <- 0, EX.v <- 0, MEM.v <- 0 (wrong path), WB <- old MEM (the branch or jump itself; JAL/JALR keeps its rd), FSM <- FLUSH.
- Stall (hz = 1, no taken branch):
  - pc_write_o = 0, if_id_write_o = 0, id_ex_bubble_o = 1, flush_o = 0.
  - At the edge: EX.v <- 0, MEM <- EX, WB <- MEM, id_valid is held, FSM <- STALL.
- Normal:
  - All enables 1, bubble 0.
  - At the edge: EX <- {id_valid & id_reg_write_i & id_rd_i != 0, id_rd_i}, MEM <- EX, WB <- MEM, id_valid <- 1, FSM <- RUN.
- FSM transitions:
  - RUN -> STALL on hz, RUN -> FLUSH on taken.
  - STALL -> STALL while hz, STALL -> RUN when clear, STALL -> FLUSH on taken.
  - FLUSH -> RUN the next cycle, or FLUSH again on a back-to-back taken.
  - state_o is the registered FSM.
- Timing and boundaries:
  - Stall length for a dependent back-to-back pair is 3 cycles (2 with RF_WRITE_THROUGH = 1); it shortens by 1 per intervening independent instruction.
  - x0 never causes a hazard.
  - The cycle after a flush never stalls, because id_valid = 0.
  - Simultaneous hz and taken: flush only, no stall.
  - A slot whose rd equals both rs1 and rs2 gives a single stall, not a double one.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined:
  - stall_cycles_o increments on every cycle with pc_write_o = 0.
  - flush_count_o increments on every cycle with flush_o = 1.
  - Both saturate at all-ones and both clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are inferred.

Test Plan:
- Reset low for 2 cycles with random inputs -> pc_write_o = 1, flush_o = 0, state_o = 0, all counters 0.
- add x1,x2,x3 then addi x4,x1,5, RF_WRITE_THROUGH = 0 -> pc_write_o = 0 for exactly 3 cycles, id_ex_bubble_o = 1 for those 3, state_o = 1, then RUN.
- Same pair with one independent instruction between, RF_WRITE_THROUGH = 1 -> 1 stall cycle.
- addi x0,x0,1 then add x5,x0,x0 -> no stall.
- branch_taken_i pulsed while ID holds a hazard on the EX slot -> flush_o = 1, pc_write_o = 1 that cycle, state_o = 2 next cycle, no stall the following cycle.
- With HAZARD_PERF_CNT_EN, run 2 hazard pairs and 1 taken branch -> stall_cycles_o = 6, flush_count_o = 1.
